mtl_lcd_scanout: RTL and testbench
==================================

// Module: mtl_lcd_scanout
// PURPOSE
// - Scan-out stage between the NES line buffer and the MTL 800x480 panel pins (MTL_R/G/B, MTL_HSD, MTL_VSD).
// - Generates the 1056x525 panel raster on the LCD pixel clock.
// - Fetches NES pixels (256x240, each pixel doubled in X and Y to 512x480) from the line buffer.
// - Centres the image horizontally and fills the rest of the active window with a border colour.
// - Also produces per-NES-line and per-frame strobes that pace the line-buffer writer.
// PARAMETERS
// H_TOTAL     1056      columns per line (0..H_TOTAL-1)
// V_TOTAL     525       lines per frame (0..V_TOTAL-1)
// H_SYNC      30        HSD low width, columns
// V_SYNC      13        VSD low width, lines
// H_ACT0      50        first active column
// V_ACT0      23        first active line
// H_ACT       800       active columns
// V_ACT       480       active lines
// IMG_X0      144       first image column, relative to H_ACT0
// BORDER_RGB  24'h0     RGB driven in active area outside image, and in blanking
// PORTS
// i_clk_lcd    in   1    LCD pixel clock (also forwarded as MTL_DCLK by top level)
// i_rstn_lcd   in   1    async active-low reset
// i_enable     in   1    1 = run raster; 0 = hold counters at 0, outputs at reset values
// o_rd_en      out  1    line-buffer read strobe
// o_rd_x       out  8    NES pixel column 0..255
// o_rd_y       out  8    NES pixel row 0..239
// i_rd_rgb     in   24   {R,G,B}, valid exactly 1 cycle after o_rd_en
// o_line_req   out  1    1-cycle pulse: next NES row should be written
// o_frame_start out 1    1-cycle pulse at output column 0 of output line 0
// o_hsd        out  1    MTL_HSD
// o_vsd        out  1    MTL_VSD
// o_rgb        out  24   {MTL_R,MTL_G,MTL_B}
// BEHAVIOUR
// - Reset (or i_enable=0):
//   - hc=0, vc=0
//   - o_hsd=1, o_vsd=1, o_rgb=BORDER_RGB
//   - o_rd_en=0, o_rd_x=0, o_rd_y=0
//   - o_line_req=0, o_frame_start=0
//   - All delay stages are cleared.
//   - Asserting reset mid-frame restarts at hc=0, vc=0 on the first edge after release.
// - Counters:
//   - hc wraps H_TOTAL-1 -> 0.
//   - vc increments when hc wraps; vc wraps V_TOTAL-1 -> 0.
// - Pipeline (3 stages):
//   - S0: counters; compute in_img = active && (hc-H_ACT0) in [IMG_X0, IMG_X0+512).
//   - S1: register o_rd_en=in_img, o_rd_x=(hc-H_ACT0-IMG_X0)>>1, o_rd_y=(vc-V_ACT0)>>1.
//   - S2: memory returns i_rd_rgb.
//   - S3: register o_rgb = S2 in_img ? i_rd_rgb : BORDER_RGB.
// - o_hsd, o_vsd and the active flag are delayed 3 cycles with S0, so pins are mutually aligned.
//   - o_hsd = !(hc_out < H_SYNC)
//   - o_vsd = !(vc_out < V_SYNC)
//   - hc_out/vc_out = S0 counters delayed 3 cycles.
// - Pixel pairing:
//   - Each o_rd_x value is held for 2 consecutive cycles; o_rd_en stays high across the whole 512-column run.
//   - Each o_rd_y value spans 2 output lines.
// - o_line_req: pulses at S0 hc==0 on lines vc = V_ACT0-2 + 2k, k=0..239.
//   - This gives the writer >= 2 line times per row.
// - o_frame_start: pulses when hc_out==0 && vc_out==0.
// - Widths: hc is 11 bits, vc is 10 bits. Subtractions are done only inside the active window (no underflow is used).
// - o_rd_x/o_rd_y never exceed 255/239.
// - Boundary cases:
//   - Column H_TOTAL-1 -> 0 and line V_TOTAL-1 -> 0 wrap with no gap cycle.
//   - i_rd_rgb is ignored whenever the delayed o_rd_en is 0.
// TESTING
// - Reset 100 cycles, release -> o_hsd=1, o_vsd=1, o_rgb=0 until the first raster output (cycle 3).
// - Free-run 2 frames:
//   - Period between o_frame_start pulses = 554400 cycles.
//   - o_hsd low 30 cycles every 1056.
//   - o_vsd low 13*1056 = 13728 cycles.
// - Line buffer model returns rgb={8'h0,y,x} (24 bits) for (x,y), BORDER_RGB=24'h123456:
//   - Output line 23: columns 194..705 show x=0,0,1,1..255,255 with y=0.
//   - Columns 50..193 and 706..849 = 24'h123456.
// - Output lines 23 and 24 are identical (y=0); line 502 carries y=239.
//   - o_rd_en is 0 on lines 0..22 and 503..524.
// - o_line_req count per frame = 240; the first pulse falls on line 21 at hc=0.
// - Drop i_rstn_lcd at line 300, column 400 for 5 cycles -> all outputs return to reset values.
//   - After release, the raster restarts; o_frame_start occurs 3 cycles after release.

Source files
------------

// File: rtl/mtl_lcd_scanout.sv
// LCD scan-out: raster timing for the MTL panel, NES line-buffer fetch with
// 2x pixel doubling, horizontal centring with a border fill, and
// line/frame pacing strobes for the line-buffer writer.
module mtl_lcd_scanout #(
  parameter int unsigned H_TOTAL    = 1056,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned H_SYNC     = 30,
  parameter int unsigned V_SYNC     = 13,
  parameter int unsigned H_ACT0     = 50,
  parameter int unsigned V_ACT0     = 23,
  parameter int unsigned H_ACT      = 800,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned IMG_X0     = 144,
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 480,
  parameter logic [23:0] BORDER_RGB = 24'h0
) (
  input  logic        i_clk_lcd,
  input  logic        i_rstn_lcd,
  input  logic        i_enable,
  output logic        o_rd_en,
  output logic [7:0]  o_rd_x,
  output logic [7:0]  o_rd_y,
  input  logic [23:0] i_rd_rgb,
  output logic        o_line_req,
  output logic        o_frame_start,
  output logic        o_hsd,
  output logic        o_vsd,
  output logic [23:0] o_rgb
);

  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned ACT_C1  = H_ACT0 + H_ACT;
  localparam int unsigned ACT_R1  = V_ACT0 + V_ACT;
  localparam int unsigned IMG_C0  = H_ACT0 + IMG_X0;
  localparam int unsigned IMG_C1  = IMG_C0 + IMG_W;
  localparam int unsigned IMG_R1  = V_ACT0 + IMG_H;
  localparam int unsigned LREQ_R0 = V_ACT0 - 2;
  localparam int unsigned LREQ_R1 = LREQ_R0 + IMG_H;

  logic [HW-1:0] hc_q, hc_d, s1_hc_q, s2_hc_q;
  logic [VW-1:0] vc_q, vc_d, s1_vc_q, s2_vc_q;
  logic [31:0]   hc_w, vc_w, hn_w, vn_w;
  logic          in_img, line_req_d;
  logic [7:0]    rd_x_d, rd_y_d;
  logic          s1_v_q, s2_v_q, s2_img_q;
  logic          rd_en_q, line_req_q, frame_start_q, hsd_q, vsd_q;
  logic [7:0]    rd_x_q, rd_y_q;
  logic [23:0]   rgb_q;

  assign hc_w = 32'(hc_q);
  assign vc_w = 32'(vc_q);
  assign hn_w = 32'(hc_d);
  assign vn_w = 32'(vc_d);

  // Raster counter next state; held at the origin while disabled.
  always_comb begin
    hc_d = '0;
    vc_d = '0;
    if (i_enable) begin
      if (hc_q == HW'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == VW'(V_TOTAL - 1)) ? '0 : vc_q + VW'(1);
      end else begin
        hc_d = hc_q + HW'(1);
        vc_d = vc_q;
      end
    end
  end

  // Raster counter registers (S0).
  always_ff @(posedge i_clk_lcd or negedge i_rstn_lcd) begin
    if (!i_rstn_lcd) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // S0 decode: image window, doubled fetch coordinates, and the line request.
  // The request is decoded from the next counter value so the registered
  // pulse coincides with S0 column 0 of every other line starting two lines
  // ahead of the image.
  always_comb begin
    rd_x_d = '0;
    rd_y_d = '0;
    in_img = (hc_w >= H_ACT0) && (hc_w < ACT_C1) &&
             (vc_w >= V_ACT0) && (vc_w < ACT_R1) &&
             (hc_w >= IMG_C0) && (hc_w < IMG_C1) && (vc_w < IMG_R1);
    if (in_img) begin
      rd_x_d = 8'((hc_w - IMG_C0) >> 1);
      rd_y_d = 8'((vc_w - V_ACT0) >> 1);
    end
    line_req_d = (hn_w == 32'd0) && (vn_w >= LREQ_R0) && (vn_w < LREQ_R1) &&
                 (((vn_w ^ LREQ_R0) & 32'd1) == 32'd0);
  end

  // S1..S3 pipeline: fetch request, memory latency slot, pin registers.
  // Sync and colour are computed from counters delayed by the same three
  // stages, so every pin describes the same raster position.
  always_ff @(posedge i_clk_lcd or negedge i_rstn_lcd) begin
    if (!i_rstn_lcd) begin
      s1_v_q <= 1'b0; s1_hc_q <= '0; s1_vc_q <= '0;
      s2_v_q <= 1'b0; s2_hc_q <= '0; s2_vc_q <= '0; s2_img_q <= 1'b0;
      rd_en_q <= 1'b0; rd_x_q <= '0; rd_y_q <= '0;
      line_req_q <= 1'b0; frame_start_q <= 1'b0;
      hsd_q <= 1'b1; vsd_q <= 1'b1; rgb_q <= BORDER_RGB;
    end else if (!i_enable) begin
      s1_v_q <= 1'b0; s1_hc_q <= '0; s1_vc_q <= '0;
      s2_v_q <= 1'b0; s2_hc_q <= '0; s2_vc_q <= '0; s2_img_q <= 1'b0;
      rd_en_q <= 1'b0; rd_x_q <= '0; rd_y_q <= '0;
      line_req_q <= 1'b0; frame_start_q <= 1'b0;
      hsd_q <= 1'b1; vsd_q <= 1'b1; rgb_q <= BORDER_RGB;
    end else begin
      s1_v_q        <= 1'b1;
      s1_hc_q       <= hc_q;
      s1_vc_q       <= vc_q;
      rd_en_q       <= in_img;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      line_req_q    <= line_req_d;
      s2_v_q        <= s1_v_q;
      s2_hc_q       <= s1_hc_q;
      s2_vc_q       <= s1_vc_q;
      s2_img_q      <= rd_en_q;
      hsd_q         <= !(s2_v_q && (32'(s2_hc_q) < H_SYNC));
      vsd_q         <= !(s2_v_q && (32'(s2_vc_q) < V_SYNC));
      frame_start_q <= s2_v_q && (s2_hc_q == '0) && (s2_vc_q == '0);
      rgb_q         <= s2_img_q ? i_rd_rgb : BORDER_RGB;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_x        = rd_x_q;
  assign o_rd_y        = rd_y_q;
  assign o_line_req    = line_req_q;
  assign o_frame_start = frame_start_q;
  assign o_hsd         = hsd_q;
  assign o_vsd         = vsd_q;
  assign o_rgb         = rgb_q;

endmodule

// File: tb/tb_mtl_lcd_scanout.sv
// Scoreboard bench for mtl_lcd_scanout on a reduced raster.
module tb_mtl_lcd_scanout;

  localparam int HT  = 100;
  localparam int VT  = 60;
  localparam int HS  = 6;
  localparam int VS  = 3;
  localparam int HA0 = 10;
  localparam int VA0 = 5;
  localparam int HA  = 80;
  localparam int VA  = 48;
  localparam int IX0 = 8;
  localparam int IW  = 64;
  localparam int IH  = 40;
  localparam logic [23:0] BORDER = 24'h123456;

  typedef struct packed {
    logic        rd_en;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        lreq;
    logic        fs;
    logic        hsd;
    logic        vsd;
    logic [23:0] rgb;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [23:0] rd_rgb = '0;
  logic        o_rd_en, o_line_req, o_frame_start, o_hsd, o_vsd;
  logic [7:0]  o_rd_x, o_rd_y;
  logic [23:0] o_rgb;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  obs_t exp_q[$];

  bit   stats_on = 0;
  bit   win_done = 0;
  int   win_cnt = -1;
  int   hl = 0, vl = 0, lr = 0, lr_first = -1;

  always #5 clk = ~clk;

  mtl_lcd_scanout #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .H_ACT0(HA0), .V_ACT0(VA0), .H_ACT(HA), .V_ACT(VA),
    .IMG_X0(IX0), .IMG_W(IW), .IMG_H(IH), .BORDER_RGB(BORDER)
  ) dut (
    .i_clk_lcd(clk), .i_rstn_lcd(rstn), .i_enable(en),
    .o_rd_en(o_rd_en), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .i_rd_rgb(rd_rgb),
    .o_line_req(o_line_req), .o_frame_start(o_frame_start),
    .o_hsd(o_hsd), .o_vsd(o_vsd), .o_rgb(o_rgb)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic bit img(input int hc, input int vc);
    return hc >= HA0 + IX0 && hc < HA0 + IX0 + IW && hc >= HA0 && hc < HA0 + HA &&
           vc >= VA0 && vc < VA0 + IH && vc < VA0 + VA;
  endfunction

  // Expected pins after k enabled clock edges since the raster origin.
  function automatic obs_t model(input int kk);
    obs_t e;
    int p, hc, vc;
    e = '0;
    e.hsd = 1'b1;
    e.vsd = 1'b1;
    e.rgb = BORDER;
    if (kk >= 1) begin
      p = kk - 1; hc = p % HT; vc = (p / HT) % VT;
      if (img(hc, vc)) begin
        e.rd_en = 1'b1;
        e.x = 8'((hc - HA0 - IX0) / 2);
        e.y = 8'((vc - VA0) / 2);
      end
    end
    hc = kk % HT; vc = (kk / HT) % VT;
    e.lreq = (hc == 0) && vc >= VA0 - 2 && vc < VA0 - 2 + IH && ((vc - (VA0 - 2)) % 2 == 0);
    if (kk >= 3) begin
      p = kk - 3; hc = p % HT; vc = (p / HT) % VT;
      e.hsd = hc >= HS;
      e.vsd = vc >= VS;
      e.fs  = (hc == 0) && (vc == 0);
      if (img(hc, vc))
        e.rgb = {8'h00, 8'((vc - VA0) / 2), 8'((hc - HA0 - IX0) / 2)};
    end
    return e;
  endfunction

  // Line buffer: one-cycle read latency, garbage whenever not being read.
  always @(posedge clk)
    rd_rgb <= o_rd_en ? {8'h00, o_rd_y, o_rd_x} : 24'($urandom);

  // Enabled-edge count since the raster origin.
  always @(posedge clk or negedge rstn)
    if (!rstn)   k <= 0;
    else if (!en) k <= 0;
    else         k <= k + 1;

  // Producer: expected pins for the current cycle.
  always @(negedge clk)
    exp_q.push_back(model(k));

  // Monitor: compare pins against the scoreboard, and gather frame statistics.
  always @(negedge clk) begin
    obs_t a, e;
    #1;
    a = '{o_rd_en, o_rd_x, o_rd_y, o_line_req, o_frame_start, o_hsd, o_vsd, o_rgb};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL pins k=%0d: got en=%b x=%0d y=%0d lreq=%b fs=%b hsd=%b vsd=%b rgb=%h, expected en=%b x=%0d y=%0d lreq=%b fs=%b hsd=%b vsd=%b rgb=%h",
                 k, a.rd_en, a.x, a.y, a.lreq, a.fs, a.hsd, a.vsd, a.rgb,
                 e.rd_en, e.x, e.y, e.lreq, e.fs, e.hsd, e.vsd, e.rgb);
      end
    end
    if (stats_on && !win_done) begin
      if (o_frame_start && win_cnt > 0) begin
        win_done = 1;
        chk("frame_period", win_cnt, HT * VT);
        chk("hsd_low_cycles", hl, HS * VT);
        chk("vsd_low_cycles", vl, VS * HT);
        chk("line_req_count", lr, IH / 2);
        chk("first_line_req_offset", lr_first, (VA0 - 2) * HT - 3);
      end else if (o_frame_start && win_cnt < 0) begin
        win_cnt = 0;
      end
      if (win_cnt >= 0 && !win_done) begin
        if (!o_hsd) hl++;
        if (!o_vsd) vl++;
        if (o_line_req) begin
          if (lr == 0) lr_first = win_cnt;
          lr++;
        end
        win_cnt++;
      end
    end
  end

  initial begin
    int n;
    en   = 1'b1;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (100) @(posedge clk);
    #2 rstn = 1'b1;
    stats_on = 1;
    repeat (2 * HT * VT + 20) @(posedge clk);
    stats_on = 0;
    chk("frame_window_seen", int'(win_done), 1);

    // Asynchronous reset mid-frame.
    n = int'($urandom_range(1000, 5000));
    repeat (n) @(posedge clk);
    #2 rstn = 1'b0;
    repeat (5) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (HT * VT + 50) @(posedge clk);

    // Enable dropped for a few cycles.
    #2 en = 1'b0;
    n = int'($urandom_range(3, 20));
    repeat (n) @(posedge clk);
    #2 en = 1'b1;
    repeat (HT * VT + 20) @(posedge clk);

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
